// File: rtl/decode_pkg.sv
// Shared types and constants for the LZS token parser.
package decode_pkg;

  typedef enum logic [1:0] {
    TOK_LIT   = 2'd0,
    TOK_MATCH = 2'd1,
    TOK_END   = 2'd2
  } tok_type_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LEN,
    ST_EXT,
    ST_ALIGN,
    ST_ERR
  } state_e;

  localparam logic [3:0] W_HDR_S = 4'd9;
  localparam logic [3:0] W_HDR_L = 4'd13;
  localparam logic [3:0] W_LEN_2 = 4'd2;
  localparam logic [3:0] W_LEN_4 = 4'd4;
  localparam logic [3:0] W_LEN_8 = 4'd8;

  typedef struct packed {
    logic [1:0]  typ;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [4:0]  len;
  } token_t;

  // Bits needed to reach the next byte boundary.
  function automatic logic [2:0] align_pad(input logic [2:0] bitpos);
    return 3'd0 - bitpos;
  endfunction

endpackage

// File: rtl/decode_token_if.sv
// Bitstream lookahead handshake and token output bus of the parser.
interface decode_token_if;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic [3:0]  stream_width;
  logic        stream_ack;
  logic        tok_valid;
  logic        tok_ready;
  logic [1:0]  tok_type;
  logic [7:0]  tok_lit;
  logic [10:0] tok_off;
  logic [4:0]  tok_len;

  modport slave (
    input  stream_data, stream_valid, tok_ready,
    output stream_width, stream_ack, tok_valid, tok_type, tok_lit, tok_off, tok_len
  );

  modport master (
    output stream_data, stream_valid, tok_ready,
    input  stream_width, stream_ack, tok_valid, tok_type, tok_lit, tok_off, tok_len
  );
endinterface

// File: rtl/decode_len.sv
// Combinational LZS length-code decoder over the top 8 lookahead bits.
module decode_len
  import decode_pkg::*;
(
  input  logic [7:0] code,
  output logic [4:0] len,
  output logic [3:0] width,
  output logic       ext
);

  always_comb begin
    len   = 5'd0;
    width = W_LEN_2;
    ext   = 1'b0;
    case (code[7:6])
      2'b00: len = 5'd2;
      2'b01: len = 5'd3;
      2'b10: len = 5'd4;
      default: begin
        width = W_LEN_4;
        case (code[5:4])
          2'b00: len = 5'd5;
          2'b01: len = 5'd6;
          2'b10: len = 5'd7;
          default: begin
            width = W_LEN_8;
            // All-ones nibble: 23 and continue with extension nibbles.
            if (code[3:0] == 4'hF) begin
              len = 5'd23;
              ext = 1'b1;
            end else begin
              len = 5'd8 + {1'b0, code[3:0]};
            end
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/decode_token.sv
// LZS token parser: classifies the lookahead window, acks consumed bits,
// and emits literal / match-segment / end tokens into a one-entry register.
module decode_token
  import decode_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  decode_token_if.slave bus,
  output logic          err
);

  state_e      state_q, state_d;
  logic [10:0] off_q, off_d;
  logic [2:0]  bitpos_q, bitpos_d;
  token_t      tok_q, tok_d, new_tok;
  logic        tok_valid_q, tok_valid_d;
  logic        err_q, err_d;

  logic        ack, emit, slot_free;
  logic [3:0]  width;
  logic [2:0]  pad;
  logic [12:0] d;
  logic [4:0]  ll_len;
  logic [3:0]  ll_width;
  logic        ll_ext;

  assign d = bus.stream_data;

  decode_len u_len (
    .code  (d[12:5]),
    .len   (ll_len),
    .width (ll_width),
    .ext   (ll_ext)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    bitpos_d    = bitpos_q;
    tok_d       = tok_q;
    tok_valid_d = tok_valid_q;
    err_d       = err_q;
    new_tok     = '0;
    ack         = 1'b0;
    emit        = 1'b0;
    width       = 4'd0;
    slot_free   = ~tok_valid_q | bus.tok_ready;
    pad         = align_pad(bitpos_q);

    if (ce && !rst) begin
      case (state_q)
        ST_HDR: if (bus.stream_valid) begin
          if (!d[12]) begin
            if (slot_free) begin
              ack         = 1'b1;
              width       = W_HDR_S;
              emit        = 1'b1;
              new_tok.typ = TOK_LIT;
              new_tok.lit = d[11:4];
            end
          end else if (d[11]) begin
            if (d[10:4] == 7'd0) begin
              if (slot_free) begin
                ack         = 1'b1;
                width       = W_HDR_S;
                emit        = 1'b1;
                new_tok.typ = TOK_END;
                state_d     = ST_ALIGN;
              end
            end else begin
              ack     = 1'b1;
              width   = W_HDR_S;
              off_d   = {4'd0, d[10:4]};
              state_d = ST_LEN;
            end
          end else if (d[10:0] == 11'd0) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            ack     = 1'b1;
            width   = W_HDR_L;
            off_d   = d[10:0];
            state_d = ST_LEN;
          end
        end
        ST_LEN: if (bus.stream_valid && slot_free) begin
          ack         = 1'b1;
          width       = ll_width;
          emit        = 1'b1;
          new_tok.typ = TOK_MATCH;
          new_tok.off = off_q;
          new_tok.len = ll_len;
          state_d     = ll_ext ? ST_EXT : ST_HDR;
        end
        ST_EXT: if (bus.stream_valid) begin
          // A zero nibble terminates the match without a token.
          if (d[12:9] == 4'd0) begin
            ack     = 1'b1;
            width   = W_LEN_4;
            state_d = ST_HDR;
          end else if (slot_free) begin
            ack         = 1'b1;
            width       = W_LEN_4;
            emit        = 1'b1;
            new_tok.typ = TOK_MATCH;
            new_tok.off = off_q;
            new_tok.len = {1'b0, d[12:9]};
            state_d     = (d[12:9] == 4'hF) ? ST_EXT : ST_HDR;
          end
        end
        ST_ALIGN: begin
          if (pad == 3'd0) begin
            state_d = ST_HDR;
          end else if (bus.stream_valid) begin
            ack     = 1'b1;
            width   = {1'b0, pad};
            state_d = ST_HDR;
          end
        end
        ST_ERR: ;
        default: state_d = ST_HDR;
      endcase

      if (ack) bitpos_d = bitpos_q + width[2:0];

      if (emit) begin
        tok_d       = new_tok;
        tok_valid_d = 1'b1;
      end else if (tok_valid_q && bus.tok_ready) begin
        tok_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR;
      off_q       <= '0;
      bitpos_q    <= '0;
      tok_q       <= '0;
      tok_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      bitpos_q    <= bitpos_d;
      tok_q       <= tok_d;
      tok_valid_q <= tok_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.stream_ack   = ack;
  assign bus.stream_width = width;
  assign bus.tok_valid    = tok_valid_q;
  assign bus.tok_type     = tok_q.typ;
  assign bus.tok_lit      = tok_q.lit;
  assign bus.tok_off      = tok_q.off;
  assign bus.tok_len      = tok_q.len;
  assign err              = err_q;

endmodule

// File: tb/tb_decode_token.sv
// Directed bench for decode_token: per-cycle window vectors with hand-computed acks and tokens.
module tb_decode_token;

  logic clk = 1'b0;
  logic rst, ce, err;
  int   n_chk  = 0;
  int   n_pass = 0;

  decode_token_if bus ();

  decode_token dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus.slave),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one window, check the combinational ack, then step past the edge.
  task automatic cyc(input string tag, input logic [12:0] d, input logic v, input logic rdy,
                     input logic exp_ack, input logic [3:0] exp_w);
    @(negedge clk);
    bus.stream_data  = d;
    bus.stream_valid = v;
    bus.tok_ready    = rdy;
    #1;
    chk({tag, "_ack"}, {31'd0, bus.stream_ack}, {31'd0, exp_ack});
    chk({tag, "_w"}, {28'd0, bus.stream_width}, {28'd0, exp_w});
    @(posedge clk);
    #1;
  endtask

  task automatic tok(input string tag, input logic [1:0] typ, input logic [7:0] lit,
                     input logic [10:0] off, input logic [4:0] len, input logic chk_lit);
    chk({tag, "_vld"}, {31'd0, bus.tok_valid}, 32'd1);
    chk({tag, "_typ"}, {30'd0, bus.tok_type}, {30'd0, typ});
    if (chk_lit) chk({tag, "_lit"}, {24'd0, bus.tok_lit}, {24'd0, lit});
    else begin
      chk({tag, "_off"}, {21'd0, bus.tok_off}, {21'd0, off});
      chk({tag, "_len"}, {27'd0, bus.tok_len}, {27'd0, len});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stream_valid = 1'b0;
    bus.tok_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    bus.stream_data  = '0;
    bus.stream_valid = 1'b0;
    bus.tok_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, bus.tok_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_typ", {30'd0, bus.tok_type}, 32'd0);
    chk("rst_lit", {24'd0, bus.tok_lit}, 32'd0);
    chk("rst_off", {21'd0, bus.tok_off}, 32'd0);
    chk("rst_len", {27'd0, bus.tok_len}, 32'd0);
    chk("rst_ack", {31'd0, bus.stream_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Literal 0x41
    cyc("lit", 13'h0410, 1, 1, 1, 4'd9);
    tok("lit_t", 2'd0, 8'h41, 0, 0, 1);

    // Short match off 1 len 2
    cyc("sm_hdr", 13'h1810, 1, 1, 1, 4'd9);
    chk("sm_drain", {31'd0, bus.tok_valid}, 32'd0);
    cyc("sm_len", 13'h0000, 1, 1, 1, 4'd2);
    tok("sm_t", 2'd1, 0, 11'd1, 5'd2, 0);

    // Long offset 0x400, len 8
    cyc("lm_hdr", 13'h1400, 1, 1, 1, 4'd13);
    chk("lm_drain", {31'd0, bus.tok_valid}, 32'd0);
    cyc("lm_len", 13'h1E00, 1, 1, 1, 4'd8);
    tok("lm_t", 2'd1, 0, 11'h400, 5'd8, 0);

    // Extended match: 23 + 15 + 3 at offset 5
    cyc("xm_hdr", 13'h1850, 1, 1, 1, 4'd9);
    cyc("xm_len", 13'h1FE0, 1, 1, 1, 4'd8);
    tok("xm_t23", 2'd1, 0, 11'd5, 5'd23, 0);
    cyc("xm_e15", 13'h1E00, 1, 1, 1, 4'd4);
    tok("xm_t15", 2'd1, 0, 11'd5, 5'd15, 0);
    cyc("xm_e3", 13'h0600, 1, 1, 1, 4'd4);
    tok("xm_t3", 2'd1, 0, 11'd5, 5'd3, 0);
    cyc("xm_hdr_back", 13'h0410, 1, 1, 1, 4'd9);

    // Literal + END at bitpos 2 -> pad 6; END at bitpos 1 -> pad 7
    do_reset();
    cyc("e_lit", 13'h0000, 1, 1, 1, 4'd9);
    cyc("e_end", 13'h1800, 1, 1, 1, 4'd9);
    tok("e_t", 2'd2, 0, 0, 0, 1);
    cyc("e_pad6", 13'h0000, 1, 1, 1, 4'd6);
    cyc("e_end2", 13'h1800, 1, 1, 1, 4'd9);
    cyc("e_pad7", 13'h0000, 1, 1, 1, 4'd7);
    // 7 literals + END = 72 bits: already aligned, no pad ack
    for (int i = 0; i < 7; i++) cyc("e_fill", 13'h0000, 1, 1, 1, 4'd9);
    cyc("e_end3", 13'h1800, 1, 1, 1, 4'd9);
    cyc("e_pad0", 13'h0000, 1, 1, 0, 4'd0);
    cyc("e_after", 13'h0410, 1, 1, 1, 4'd9);
    tok("e_after_t", 2'd0, 8'h41, 0, 0, 1);

    // Gating by ce and stream_valid
    ce = 1'b0;
    cyc("ce_lo", 13'h0420, 1, 1, 0, 4'd0);
    chk("ce_hold", {31'd0, bus.tok_valid}, 32'd1);
    ce = 1'b1;
    cyc("sv_lo", 13'h0420, 0, 1, 0, 4'd0);

    // 11-bit offset 0 is a format error
    do_reset();
    cyc("er_hdr", 13'h1000, 1, 1, 0, 4'd0);
    chk("er_flag", {31'd0, err}, 32'd1);
    cyc("er_stuck", 13'h0410, 1, 1, 0, 4'd0);
    chk("er_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("er_clr", {31'd0, err}, 32'd0);

    // Backpressure across three literals
    cyc("bp_a", 13'h0410, 1, 0, 1, 4'd9);
    tok("bp_a_t", 2'd0, 8'h41, 0, 0, 1);
    cyc("bp_b0", 13'h0420, 1, 0, 0, 4'd0);
    cyc("bp_b1", 13'h0420, 1, 0, 0, 4'd0);
    chk("bp_hold", {24'd0, bus.tok_lit}, 32'h41);
    cyc("bp_b", 13'h0420, 1, 1, 1, 4'd9);
    tok("bp_b_t", 2'd0, 8'h42, 0, 0, 1);
    cyc("bp_c", 13'h0430, 1, 1, 1, 4'd9);
    tok("bp_c_t", 2'd0, 8'h43, 0, 0, 1);
    cyc("bp_idle", 13'h0000, 0, 1, 0, 4'd0);
    chk("bp_empty", {31'd0, bus.tok_valid}, 32'd0);

    // Terminating zero nibble proceeds with a full slot
    do_reset();
    cyc("z_hdr", 13'h1850, 1, 0, 1, 4'd9);
    cyc("z_len", 13'h1FE0, 1, 0, 1, 4'd8);
    tok("z_t23", 2'd1, 0, 11'd5, 5'd23, 0);
    cyc("z_ext0", 13'h0000, 1, 0, 1, 4'd4);
    tok("z_keep", 2'd1, 0, 11'd5, 5'd23, 0);
    cyc("z_stall", 13'h0410, 1, 0, 0, 4'd0);
    cyc("z_go", 13'h0410, 1, 1, 1, 4'd9);
    tok("z_lit", 2'd0, 8'h41, 0, 0, 1);
    do_reset();
    chk("z_rst_drop", {31'd0, bus.tok_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
